// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared definitions for the BCD <-> binary conversion blocks.
package bcd_pkg;

    typedef enum logic [2:0] {
        IDLE              = 3'd0,
        SHIFT             = 3'd1,
        CHECK_SHIFT_INDEX = 3'd2,
        SUB               = 3'd3,
        CHECK_DIGIT_INDEX = 3'd4,
        DONE              = 3'd5
    } t_bcd_state;

    localparam logic [3:0] BCD_SUB_THRESHOLD = 4'd8;
    localparam logic [3:0] BCD_SUB_VALUE     = 4'd3;
    localparam logic [3:0] BCD_MAX_DIGIT     = 4'd9;

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Request/result bundle between a decimal-entry source and the BCD-to-binary converter.
interface bcd_to_binary_seq_if #(
    parameter int unsigned DECIMAL_DIGITS = 4,
    parameter int unsigned OUTPUT_WIDTH   = 14
);

    logic [DECIMAL_DIGITS*4-1:0] i_BCD;
    logic                        i_Start;
    logic [OUTPUT_WIDTH-1:0]     o_Binary;
    logic                        o_DV;
    logic                        o_Busy;
    logic                        o_Error;
    logic                        o_Overflow;

    modport master (
        output i_BCD, i_Start,
        input  o_Binary, o_DV, o_Busy, o_Error, o_Overflow
    );

    modport slave (
        input  i_BCD, i_Start,
        output o_Binary, o_DV, o_Busy, o_Error, o_Overflow
    );

endinterface

// File: rtl/bcd_to_binary_seq.sv
// Iterative BCD-to-binary converter (reverse double-dabble: shift right, then
// subtract 3 from every digit >= 8), one digit correction per SUB cycle.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DECIMAL_DIGITS = 4,
    parameter int unsigned OUTPUT_WIDTH   = 14
) (
    input logic              i_Clock,
    input logic              i_Reset,
    bcd_to_binary_seq_if.slave bus
);

    localparam int unsigned     BCD_W      = DECIMAL_DIGITS * 4;
    localparam int unsigned     IDX_W      = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(DECIMAL_DIGITS - 1);
    localparam logic [7:0]      LAST_LOOP  = 8'(OUTPUT_WIDTH - 1);

    t_bcd_state              state;
    logic [BCD_W-1:0]        r_BCD;
    logic [OUTPUT_WIDTH-1:0] r_Bin;
    logic [7:0]              r_Loop_Count;
    logic [IDX_W-1:0]        r_Digit_Index;
    logic                    r_Err;

    logic [OUTPUT_WIDTH-1:0] r_Binary_Out;
    logic                    r_DV;
    logic                    r_Error_Out;
    logic                    r_Overflow_Out;

    logic [DECIMAL_DIGITS-1:0]     nibble_bad;
    logic                          any_bad;
    logic [BCD_W+OUTPUT_WIDTH-1:0] shifted;
    logic [BCD_W-1:0]              bcd_adjusted;

    for (genvar g = 0; g < DECIMAL_DIGITS; g++) begin : g_valid
        assign nibble_bad[g] = (bus.i_BCD[g*4 +: 4] > BCD_MAX_DIGIT);
    end

    assign any_bad = |nibble_bad;
    assign shifted = {r_BCD, r_Bin} >> 1;

    // Only the digit selected by r_Digit_Index is corrected; no borrow crosses nibbles.
    always_comb begin
        bcd_adjusted = r_BCD;
        for (int unsigned d = 0; d < DECIMAL_DIGITS; d++) begin
            if ((IDX_W'(d) == r_Digit_Index) && (r_BCD[d*4 +: 4] >= BCD_SUB_THRESHOLD)) begin
                bcd_adjusted[d*4 +: 4] = r_BCD[d*4 +: 4] - BCD_SUB_VALUE;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state          <= IDLE;
            r_BCD          <= '0;
            r_Bin          <= '0;
            r_Loop_Count   <= '0;
            r_Digit_Index  <= '0;
            r_Err          <= 1'b0;
            r_Binary_Out   <= '0;
            r_DV           <= 1'b0;
            r_Error_Out    <= 1'b0;
            r_Overflow_Out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    r_DV <= 1'b0;
                    if (bus.i_Start) begin
                        r_BCD <= bus.i_BCD;
                        r_Bin <= '0;
                        r_Err <= any_bad;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {r_BCD, r_Bin} <= shifted;
                    state          <= CHECK_SHIFT_INDEX;
                end
                CHECK_SHIFT_INDEX: begin
                    if (r_Loop_Count == LAST_LOOP) begin
                        r_Loop_Count <= '0;
                        state        <= DONE;
                    end else begin
                        r_Loop_Count <= r_Loop_Count + 8'd1;
                        state        <= SUB;
                    end
                end
                SUB: begin
                    r_BCD <= bcd_adjusted;
                    state <= CHECK_DIGIT_INDEX;
                end
                CHECK_DIGIT_INDEX: begin
                    if (r_Digit_Index == LAST_DIGIT) begin
                        r_Digit_Index <= '0;
                        state         <= SHIFT;
                    end else begin
                        r_Digit_Index <= r_Digit_Index + 1'b1;
                        state         <= SUB;
                    end
                end
                DONE: begin
                    r_DV           <= 1'b1;
                    r_Overflow_Out <= (r_BCD != '0);
                    r_Error_Out    <= r_Err;
                    r_Binary_Out   <= r_Err ? '0 : r_Bin;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_Binary   = r_Binary_Out;
    assign bus.o_DV       = r_DV;
    assign bus.o_Busy     = (state != IDLE);
    assign bus.o_Error    = r_Error_Out;
    assign bus.o_Overflow = r_Overflow_Out;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Bench for bcd_to_binary_seq: default build plus a 2-digit/4-bit build, scoreboard-checked.
module tb_bcd_to_binary_seq;

    localparam int unsigned LAT_A = 133;
    localparam int unsigned LAT_B = 21;

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] bin;
        logic        err;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] bin;
        logic        err;
        logic        ovf;
        int unsigned acc;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned dv_a = 0;
    int unsigned dv_b = 0;

    sb_t qa[$];
    sb_t qb[$];
    sb_t exp_a, exp_b, push_e, mon_a, mon_b;

    vec_t va[8];
    vec_t vb[5];

    always #5 clk = ~clk;

    bcd_to_binary_seq_if #(.DECIMAL_DIGITS(4), .OUTPUT_WIDTH(14)) ifa ();
    bcd_to_binary_seq_if #(.DECIMAL_DIGITS(2), .OUTPUT_WIDTH(4))  ifb ();

    bcd_to_binary_seq #(.DECIMAL_DIGITS(4), .OUTPUT_WIDTH(14)) dut_a (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (ifa)
    );

    bcd_to_binary_seq #(.DECIMAL_DIGITS(2), .OUTPUT_WIDTH(4)) dut_b (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (ifb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Accept tracker: a start seen while idle and out of reset enters the scoreboard.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (ifa.i_Start === 1'b1 && ifa.o_Busy === 1'b0) begin
                push_e = exp_a;
                push_e.acc = cyc + 1;
                qa.push_back(push_e);
            end
            if (ifb.i_Start === 1'b1 && ifb.o_Busy === 1'b0) begin
                push_e = exp_b;
                push_e.acc = cyc + 1;
                qb.push_back(push_e);
            end
        end
    end

    always @(negedge clk) begin
        if (ifa.o_DV === 1'b1) begin
            dv_a++;
            if (qa.size() == 0) begin
                check("a_unexpected_dv", 1, 0);
            end else begin
                mon_a = qa.pop_front();
                check("a_binary", 32'(ifa.o_Binary), 32'(mon_a.bin));
                check("a_error", 32'(ifa.o_Error), 32'(mon_a.err));
                check("a_overflow", 32'(ifa.o_Overflow), 32'(mon_a.ovf));
                check("a_latency", cyc - mon_a.acc, LAT_A);
                check("a_busy_at_dv", 32'(ifa.o_Busy), 0);
            end
        end else if (qa.size() > 0) begin
            check("a_busy", 32'(ifa.o_Busy), 1);
        end
    end

    always @(negedge clk) begin
        if (ifb.o_DV === 1'b1) begin
            dv_b++;
            if (qb.size() == 0) begin
                check("b_unexpected_dv", 1, 0);
            end else begin
                mon_b = qb.pop_front();
                check("b_binary", 32'(ifb.o_Binary), 32'(mon_b.bin));
                check("b_error", 32'(ifb.o_Error), 32'(mon_b.err));
                check("b_overflow", 32'(ifb.o_Overflow), 32'(mon_b.ovf));
                check("b_latency", cyc - mon_b.acc, LAT_B);
            end
        end
    end

    task automatic wait_dv_a(input int unsigned bound);
        bit seen = 1'b0;
        for (int unsigned i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (ifa.o_DV === 1'b1) seen = 1'b1;
        end
        check("a_dv_seen", 32'(seen), 1);
    endtask

    task automatic wait_dv_b(input int unsigned bound);
        bit seen = 1'b0;
        for (int unsigned i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (ifb.o_DV === 1'b1) seen = 1'b1;
        end
        check("b_dv_seen", 32'(seen), 1);
    endtask

    task automatic run_a(input vec_t v);
        @(negedge clk);
        exp_a.bin   = v.bin;
        exp_a.err   = v.err;
        exp_a.ovf   = v.ovf;
        ifa.i_BCD   = v.bcd;
        ifa.i_Start = 1'b1;
        @(negedge clk);
        ifa.i_Start = 1'b0;
        wait_dv_a(LAT_A + 20);
    endtask

    task automatic run_b(input vec_t v);
        @(negedge clk);
        exp_b.bin   = v.bin;
        exp_b.err   = v.err;
        exp_b.ovf   = v.ovf;
        ifb.i_BCD   = v.bcd[7:0];
        ifb.i_Start = 1'b1;
        @(negedge clk);
        ifb.i_Start = 1'b0;
        wait_dv_b(LAT_B + 20);
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_binary"}, 32'(ifa.o_Binary), 0);
        check({tag, "_dv"}, 32'(ifa.o_DV), 0);
        check({tag, "_busy"}, 32'(ifa.o_Busy), 0);
        check({tag, "_error"}, 32'(ifa.o_Error), 0);
        check({tag, "_overflow"}, 32'(ifa.o_Overflow), 0);
    endtask

    initial begin
        int unsigned t1, t2, n;

        va[0] = '{16'h9999, 16'd9999, 1'b0, 1'b0};
        va[1] = '{16'h0000, 16'd0,    1'b0, 1'b0};
        va[2] = '{16'h0001, 16'd1,    1'b0, 1'b0};
        va[3] = '{16'h1000, 16'd1000, 1'b0, 1'b0};
        va[4] = '{16'h12A4, 16'd0,    1'b1, 1'b0};
        va[5] = '{16'h4321, 16'd4321, 1'b0, 1'b0};
        va[6] = '{16'h0808, 16'd808,  1'b0, 1'b0};
        va[7] = '{16'h2048, 16'd2048, 1'b0, 1'b0};

        vb[0] = '{16'h0010, 16'd10, 1'b0, 1'b0};
        vb[1] = '{16'h0016, 16'd0,  1'b0, 1'b1};
        vb[2] = '{16'h0015, 16'd15, 1'b0, 1'b0};
        vb[3] = '{16'h0099, 16'd3,  1'b0, 1'b1};
        vb[4] = '{16'h0000, 16'd0,  1'b0, 1'b0};

        exp_a = '{16'd0, 1'b0, 1'b0, 0};
        exp_b = '{16'd0, 1'b0, 1'b0, 0};
        ifa.i_BCD = '0;
        ifa.i_Start = 1'b0;
        ifb.i_BCD = '0;
        ifb.i_Start = 1'b0;

        repeat (3) @(negedge clk);
        check_idle_a("rst_a");
        check("rst_b_binary", 32'(ifb.o_Binary), 0);
        check("rst_b_busy", 32'(ifb.o_Busy), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_a(va[i]);
        for (int i = 0; i < 5; i++) run_b(vb[i]);

        // Re-pulse of start mid-conversion with a different value must be ignored.
        @(negedge clk);
        exp_a = '{16'd42, 1'b0, 1'b0, 0};
        ifa.i_BCD = 16'h0042;
        ifa.i_Start = 1'b1;
        @(negedge clk);
        ifa.i_Start = 1'b0;
        repeat (49) @(negedge clk);
        exp_a = '{16'd777, 1'b0, 1'b0, 0};
        ifa.i_BCD = 16'h0777;
        ifa.i_Start = 1'b1;
        @(negedge clk);
        ifa.i_Start = 1'b0;
        wait_dv_a(LAT_A + 20);

        // Held start: two back-to-back conversions.
        @(negedge clk);
        exp_a = '{16'd42, 1'b0, 1'b0, 0};
        ifa.i_BCD = 16'h0042;
        ifa.i_Start = 1'b1;
        wait_dv_a(LAT_A + 20);
        t1 = cyc;
        wait_dv_a(LAT_A + 20);
        t2 = cyc;
        ifa.i_Start = 1'b0;
        check("a_b2b_spacing", t2 - t1, LAT_A + 1);

        // Reset in the middle of a conversion.
        @(negedge clk);
        exp_a = '{16'd5555, 1'b0, 1'b0, 0};
        ifa.i_BCD = 16'h5555;
        ifa.i_Start = 1'b1;
        @(negedge clk);
        ifa.i_Start = 1'b0;
        repeat (59) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_a("abort_a");
        n = dv_a;
        repeat (LAT_A + 20) @(negedge clk);
        check("a_no_dv_after_abort", dv_a, n);
        run_a('{16'h0123, 16'd123, 1'b0, 1'b0});

        repeat (5) @(negedge clk);
        check("a_scoreboard_empty", qa.size(), 0);
        check("b_scoreboard_empty", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
- Sequential BCD-to-binary converter. It is the inverse of the team's iterative binary-to-BCD block.
- Converts a packed DECIMAL_DIGITS-digit BCD value into an unsigned OUTPUT_WIDTH-bit binary value using the reverse double-dabble algorithm: shift right, then subtract 3 from any digit ≥ 8.
- Sits between the keypad/UART decimal-entry path and the arithmetic datapath.
- Flags invalid BCD digits and results that do not fit in OUTPUT_WIDTH bits.

Parameters:
- DECIMAL_DIGITS, 4, number of packed BCD input digits (≥ 1).
- OUTPUT_WIDTH, 14, binary result width; 1..255 (8-bit loop counter).

Ports:
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_BCD  in  DECIMAL_DIGITS*4  packed BCD; digit 0 in bits [3:0].
- i_Start  in  1  start request; sampled only in IDLE.
- o_Binary  out  OUTPUT_WIDTH  result; registered, held until next completion.
- o_DV  out  1  single-cycle pulse: result, error and overflow flags valid.
- o_Busy  out  1  high in every state except IDLE.
- o_Error  out  1  at least one input nibble was > 9; held with o_Binary.
- o_Overflow  out  1  input value ≥ 2^OUTPUT_WIDTH; held with o_Binary.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - On reset, all outputs go to 0, state goes to IDLE, and counters and working registers clear.
  - Reset mid-conversion aborts the conversion; no o_DV is produced.
- Working registers:
  - r_BCD, DECIMAL_DIGITS*4 bits.
  - r_Bin, OUTPUT_WIDTH bits.
  - r_Loop_Count, 8 bits.
  - r_Digit_Index, $clog2(DECIMAL_DIGITS) bits, minimum 1.
  - r_Err, latched error flag.
- State machine:
  - IDLE:
    - o_DV <= 0.
    - If i_Start: r_BCD <= i_BCD, r_Bin <= 0, r_Err <= (any nibble > 9), go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT: shift {r_BCD, r_Bin} right by 1. r_BCD[0] enters r_Bin[MSB]; 0 enters r_BCD[MSB]. Go to CHECK_SHIFT_INDEX.
  - CHECK_SHIFT_INDEX:
    - If r_Loop_Count == OUTPUT_WIDTH-1: clear the counter and go to DONE.
    - Otherwise increment the counter and go to SUB.
  - SUB: if digit[r_Digit_Index] ≥ 8, subtract 3 from it in place (4-bit arithmetic, no borrow into neighbouring digits). Go to CHECK_DIGIT_INDEX.
  - CHECK_DIGIT_INDEX:
    - If the last digit: clear the index and go to SHIFT.
    - Otherwise increment the index and go to SUB.
  - DONE:
    - o_DV <= 1.
    - o_Overflow <= (r_BCD != 0), i.e. a residual remains after OUTPUT_WIDTH shifts.
    - o_Error <= r_Err.
    - o_Binary <= r_Err ? 0 : r_Bin. On overflow without error, o_Binary carries the value mod 2^OUTPUT_WIDTH.
    - Go to IDLE.
  - Any unused encoding goes to IDLE.
- Latency:
  - Measured from the rising edge that samples i_Start in IDLE.
  - o_DV is high after edge (OUTPUT_WIDTH-1)*(2+2*DECIMAL_DIGITS)+3.
  - Defaults: 133 edges. With OUTPUT_WIDTH=4, DECIMAL_DIGITS=2: 21 edges.
- Handshake:
  - i_Start while o_Busy is ignored; no queueing.
  - i_Start may be held high, giving back-to-back conversions with one IDLE cycle between them. o_DV and the next start-accept share that IDLE edge.
  - i_BCD is sampled only on the start-accept edge; later changes have no effect.
- Simultaneous reset and start: reset wins.
- o_Busy is combinational from the state (not IDLE). It is 0 in the o_DV cycle, because state is already IDLE then.

Decomposition:
- Package bcd_pkg:
  - State enum t_bcd_state: IDLE, SHIFT, CHECK_SHIFT_INDEX, SUB, CHECK_DIGIT_INDEX, DONE (3-bit).
  - Constants BCD_SUB_THRESHOLD=8, BCD_SUB_VALUE=3, BCD_MAX_DIGIT=9.
  - The package is shared with the binary-to-BCD block.
- No sub-module; the digit-validity check is a generate loop in the top.

Test Plan:
- Defaults, i_BCD=16'h9999, one-cycle start -> o_DV pulse exactly 133 edges later; o_Binary=14'd9999 (0x270F); o_Error=0; o_Overflow=0; o_Busy high throughout.
- Defaults, i_BCD=16'h0000, then 16'h0001, then 16'h1000 -> o_Binary=0, 1, 1000; no flags.
- Defaults, i_BCD=16'h12A4 -> o_Error=1, o_Binary=0, o_Overflow=0.
- OUTPUT_WIDTH=4, DECIMAL_DIGITS=2:
  - i_BCD=8'h10 -> o_Binary=4'd10 at 21 edges, no flags.
  - i_BCD=8'h16 -> o_Overflow=1, o_Binary=4'd0.
  - i_BCD=8'h15 -> o_Binary=4'd15, o_Overflow=0.
- Defaults, start 16'h0042; re-pulse i_Start with 16'h0777 at edge 50 -> ignored, result 42. Then hold i_Start high -> back-to-back results 42 and 42, DV pulses 134 edges apart.
- Defaults, start 16'h5555; assert i_Reset at edge 60 for one cycle -> no o_DV, all outputs 0. New start with 16'h0123 -> o_Binary=123 after 133 edges.
